// File: rtl/result_checker_pkg.sv
// Shared definitions for the result checker: FSM encoding and count helper.
`timescale 1ns/1ps
package result_checker_pkg;

    // Run-control FSM encoding, also used by the bench to inspect state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_W = 32;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/result_checker_if.sv
// Expected-result and DUT-result streams feeding the result checker.
`timescale 1ns/1ps
interface result_checker_if #(
    parameter int WIDTH = 32
);
    logic             i_exp_valid;
    logic [WIDTH-1:0] i_exp_data;
    logic             o_exp_ready;
    logic             i_dut_valid;
    logic [WIDTH-1:0] i_dut_data;

    // Producer side: golden model and DUT.
    modport master (
        output i_exp_valid,
        output i_exp_data,
        input  o_exp_ready,
        output i_dut_valid,
        output i_dut_data
    );

    // Consumer side: the checker.
    modport slave (
        input  i_exp_valid,
        input  i_exp_data,
        output o_exp_ready,
        input  i_dut_valid,
        input  i_dut_data
    );
endinterface

// File: rtl/result_checker_sync_fifo.sv
// Single-clock FIFO holding expected results until the matching DUT result arrives.
// Head is read combinationally so the compare can happen in the pop cycle.
`timescale 1ns/1ps
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Storage write; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy spans 0..DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/result_checker.sv
// Compares DUT results against queued golden results and produces a one-cycle
// freeze-low / event pulse per comparison for a downstream scoreboard.
`timescale 1ns/1ps
module result_checker
    import result_checker_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [31:0]           i_num_samples,
    result_checker_if.slave       bus,
    output logic                  o_event,
    output logic                  o_freeze,
    output logic                  o_done,
    output logic                  o_underflow
);
    state_e           state_r;
    state_e           next_state_s;
    logic [31:0]      count_r;
    logic [31:0]      target_r;
    logic             freeze_r;
    logic             event_r;
    logic             underflow_r;

    logic             start_s;
    logic             exp_ready_s;
    logic             push_s;
    logic             cmp_s;
    logic             under_s;
    logic             last_cmp_s;
    logic [WIDTH-1:0] head_s;
    logic             full_s;
    logic             empty_s;

    // Start is only honoured outside RUN; it also flushes the FIFO.
    assign start_s     = i_start && (state_r != RUN);
    assign exp_ready_s = (state_r == RUN) && !full_s;
    assign push_s      = bus.i_exp_valid && exp_ready_s;
    // No bypass: a same-cycle push never satisfies a DUT result on an empty FIFO.
    assign cmp_s       = (state_r == RUN) && bus.i_dut_valid && !empty_s;
    assign under_s     = (state_r == RUN) && bus.i_dut_valid && empty_s;
    // The compare that brings the count to a nonzero target ends the run at once;
    // its registered pulse then lands in the first DONE cycle.
    assign last_cmp_s  = cmp_s && (target_r != 32'd0) && (sat_inc(count_r) == target_r);

    assign bus.o_exp_ready = exp_ready_s;
    assign o_freeze        = freeze_r;
    assign o_event         = event_r;
    assign o_done          = (state_r == DONE);
    assign o_underflow     = underflow_r;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (start_s),
        .push      (push_s),
        .push_data (bus.i_exp_data),
        .pop       (cmp_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (last_cmp_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = RUN;
                end
            end
            DONE: begin
                if (i_start) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Run bookkeeping: target latch, saturating compare count, sticky underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r     <= 32'd0;
            target_r    <= 32'd0;
            underflow_r <= 1'b0;
        end else if (start_s) begin
            count_r     <= 32'd0;
            target_r    <= i_num_samples;
            underflow_r <= 1'b0;
        end else begin
            if (cmp_s) begin
                count_r <= sat_inc(count_r);
            end
            if (under_s) begin
                underflow_r <= 1'b1;
            end
        end
    end

    // Registered comparison pulse, one cycle after the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            freeze_r <= 1'b1;
            event_r  <= 1'b0;
        end else begin
            freeze_r <= !cmp_s;
            event_r  <= cmp_s && (head_s != bus.i_dut_data);
        end
    end
endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with a small scoreboard-counter model.
`timescale 1ns/1ps
module tb_result_checker;
    import result_checker_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_start;
    logic [31:0] i_num_samples;
    logic        o_event;
    logic        o_freeze;
    logic        o_done;
    logic        o_underflow;

    result_checker_if #(.WIDTH(WIDTH)) bus ();

    result_checker #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_num_samples (i_num_samples),
        .bus           (bus.slave),
        .o_event       (o_event),
        .o_freeze      (o_freeze),
        .o_done        (o_done),
        .o_underflow   (o_underflow)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Scoreboard model: counts data beats (freeze low) and mismatch events.
    logic sb_clr;
    int   sb_data_cnt;
    int   sb_event_cnt;

    always @(posedge clk) begin
        if (sb_clr || reset) begin
            sb_data_cnt  <= 0;
            sb_event_cnt <= 0;
        end else begin
            if (!o_freeze) sb_data_cnt <= sb_data_cnt + 1;
            if (o_event)   sb_event_cnt <= sb_event_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          fl_cnt;
    int          ev_cnt;
    int          ev_idx;
    logic        done_at_last;
    logic [31:0] dut_vec [4];

    initial begin
        reset            = 1'b1;
        i_start          = 1'b0;
        i_num_samples    = 32'd0;
        bus.i_exp_valid  = 1'b0;
        bus.i_exp_data   = 32'd0;
        bus.i_dut_valid  = 1'b0;
        bus.i_dut_data   = 32'd0;
        sb_clr           = 1'b1;
        tick();
        tick();

        // Reset state
        check_eq("rst_freeze", o_freeze, 1);
        check_eq("rst_event", o_event, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_underflow", o_underflow, 0);
        check_eq("rst_exp_ready", bus.o_exp_ready, 0);
        check_eq("rst_state", dut.state_r, IDLE);
        reset  = 1'b0;
        sb_clr = 1'b0;

        // 4-sample run
        i_start = 1'b1; i_num_samples = 32'd4;
        tick();
        i_start = 1'b0;
        check_eq("run_state", dut.state_r, RUN);
        check_eq("run_exp_ready", bus.o_exp_ready, 1);

        // Underflow on empty FIFO
        bus.i_dut_valid = 1'b1; bus.i_dut_data = 32'h55;
        tick();
        bus.i_dut_valid = 1'b0;
        check_eq("uf_set", o_underflow, 1);
        check_eq("uf_freeze", o_freeze, 1);
        check_eq("uf_count", dut.count_r, 0);
        tick();
        check_eq("uf_sticky", o_underflow, 1);

        for (int k = 1; k <= 5; k++) begin
            bus.i_exp_valid = 1'b1; bus.i_exp_data = 32'(k);
            tick();
        end
        bus.i_exp_valid = 1'b0;
        check_eq("run_occ5", dut.u_fifo.count_r, 5);

        dut_vec[0] = 32'd1; dut_vec[1] = 32'd2; dut_vec[2] = 32'd9; dut_vec[3] = 32'd4;
        fl_cnt = 0; ev_cnt = 0; ev_idx = -1;
        for (int k = 0; k < 4; k++) begin
            bus.i_dut_valid = 1'b1; bus.i_dut_data = dut_vec[k];
            tick();
            if (!o_freeze) fl_cnt++;
            if (o_event) begin
                ev_cnt++;
                ev_idx = k;
            end
        end
        done_at_last = o_done;
        bus.i_dut_valid = 1'b0;
        tick();
        check_eq("run_freeze_lows", fl_cnt, 4);
        check_eq("run_events", ev_cnt, 1);
        check_eq("run_event_idx", ev_idx, 2);
        check_eq("run_done_last", done_at_last, 1);
        check_eq("done_freeze", o_freeze, 1);
        check_eq("done_event", o_event, 0);
        check_eq("done_hold", o_done, 1);
        check_eq("done_uf_kept", o_underflow, 1);

        // Inputs ignored in DONE
        bus.i_dut_valid = 1'b1; bus.i_dut_data = 32'd0;
        bus.i_exp_valid = 1'b1; bus.i_exp_data = 32'd77;
        tick();
        bus.i_dut_valid = 1'b0; bus.i_exp_valid = 1'b0;
        check_eq("done_ign_freeze", o_freeze, 1);
        check_eq("done_ign_occ", dut.u_fifo.count_r, 1);
        check_eq("done_exp_ready", bus.o_exp_ready, 0);
        tick();
        check_eq("sb_data", sb_data_cnt, 4);
        check_eq("sb_event", sb_event_cnt, 1);

        // Restart unbounded from DONE
        i_start = 1'b1; i_num_samples = 32'd0;
        tick();
        i_start = 1'b0;
        check_eq("rs_occ", dut.u_fifo.count_r, 0);
        check_eq("rs_uf_clr", o_underflow, 0);
        check_eq("rs_done", o_done, 0);
        check_eq("rs_exp_ready", bus.o_exp_ready, 1);
        bus.i_exp_valid = 1'b1; bus.i_exp_data = 32'd7;
        tick();
        bus.i_exp_valid = 1'b0;
        bus.i_dut_valid = 1'b1; bus.i_dut_data = 32'd7;
        tick();
        bus.i_dut_valid = 1'b0;
        check_eq("rs_flush_freeze", o_freeze, 0);
        check_eq("rs_flush_event", o_event, 0);

        // Fill to DEPTH
        for (int k = 0; k < 8; k++) begin
            bus.i_exp_valid = 1'b1; bus.i_exp_data = 32'(16 + k);
            tick();
        end
        check_eq("fill_ready", bus.o_exp_ready, 0);
        check_eq("fill_occ", dut.u_fifo.count_r, 8);
        bus.i_exp_data = 32'd99;
        bus.i_dut_valid = 1'b1; bus.i_dut_data = 32'd16;
        tick();
        check_eq("full_pop_occ", dut.u_fifo.count_r, 7);
        check_eq("full_pop_event", o_event, 0);
        bus.i_exp_data = 32'd24; bus.i_dut_data = 32'd17;
        tick();
        bus.i_exp_valid = 1'b0;
        check_eq("pushpop_occ", dut.u_fifo.count_r, 7);
        check_eq("pushpop_freeze", o_freeze, 0);
        bus.i_dut_data = 32'd0;
        tick();
        check_eq("mis_event", o_event, 1);
        for (int k = 19; k <= 21; k++) begin
            bus.i_dut_data = 32'(k);
            tick();
        end
        bus.i_dut_valid = 1'b0;
        check_eq("unb_count", dut.count_r, 7);
        check_eq("unb_done", o_done, 0);
        check_eq("unb_occ3", dut.u_fifo.count_r, 3);

        // Reset mid-run with a compare in flight
        reset = 1'b1;
        bus.i_dut_valid = 1'b1; bus.i_dut_data = 32'd22;
        tick();
        reset = 1'b0;
        check_eq("mr_state", dut.state_r, IDLE);
        check_eq("mr_freeze", o_freeze, 1);
        check_eq("mr_event", o_event, 0);
        check_eq("mr_occ", dut.u_fifo.count_r, 0);
        check_eq("mr_exp_ready", bus.o_exp_ready, 0);
        tick();
        bus.i_dut_valid = 1'b0;
        check_eq("mr_ign_freeze", o_freeze, 1);
        check_eq("mr_ign_uf", o_underflow, 0);
        check_eq("mr_ign_state", dut.state_r, IDLE);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
